serial_rx: RTL

Receive-side deserializer for the 32-bit serial word link. It recovers words sent as sclk / data_enable / sdo, where sdo changes on the sclk rising edge and data_enable frames each word. It runs on the system clock, oversamples the link through synchronizers and presents each complete word on a valid/ready interface to the display/calculator logic.

---
 rtl/serial_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/serial_rx.sv
// serial_rx: receive-side deserializer for the 32-bit serial word link.
// Oversamples sclk / data_enable / sdi on clk through synchronizers, shifts
// sdi in on sclk falling edges and hands each complete word to the consumer
// over a valid/ready interface.
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   sclk             serial clock from the transmitter (async)
//   data_enable      frame enable (async)
//   sdi              serial data, MSB first (async)
//   data_out         last accepted word
//   data_valid       data_out holds an unconsumed word
//   data_ready       consumer accepts on data_valid & data_ready
//   frame_err        one-clk pulse: frame ended with wrong bit count
//   overrun          one-clk pulse: good frame dropped, holding register full
module serial_rx #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LEAD_BITS   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             data_enable,
  input  logic             sdi,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CNT_W   = $clog2(WIDTH + 2);
  localparam int unsigned LEAD_W  = (LEAD_BITS > 0) ? $clog2(LEAD_BITS + 1) : 1;
  localparam int unsigned PRIME_W = SYNC_STAGES + 1;

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_pipe, de_pipe, sdi_pipe;
  logic               sclk_d, de_d;
  logic [PRIME_W-1:0] prime;
  logic               armed;
  logic [LEAD_W-1:0]  lead_cnt, lead_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_nxt;
  logic [WIDTH-1:0]   shift, shift_nxt;
  logic [WIDTH-1:0]   data_out_nxt;
  logic               valid_nxt, err_nxt, ovr_nxt;

  logic sclk_s, de_s, sdi_s;
  logic sclk_fall, de_rise, de_fall, primed;

  assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
  assign de_s      = de_pipe[SYNC_STAGES-1];
  assign sdi_s     = sdi_pipe[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign de_rise   = de_s & ~de_d;
  assign de_fall   = ~de_s & de_d;
  // Synchronizer and delay flops hold real input samples only once primed;
  // the reset zeros must not be mistaken for a genuine data_enable low.
  assign primed    = prime[PRIME_W-1];

  // Synchronizers, edge-detect delays and all registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_pipe  <= '0;
      de_pipe    <= '0;
      sdi_pipe   <= '0;
      sclk_d     <= 1'b0;
      de_d       <= 1'b0;
      prime      <= '0;
      armed      <= 1'b0;
      state      <= IDLE;
      lead_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sclk_pipe  <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
      de_pipe    <= {de_pipe[SYNC_STAGES-2:0], data_enable};
      sdi_pipe   <= {sdi_pipe[SYNC_STAGES-2:0], sdi};
      sclk_d     <= sclk_s;
      de_d       <= de_s;
      prime      <= {prime[PRIME_W-2:0], 1'b1};
      armed      <= armed | (primed & ~de_s);
      state      <= state_nxt;
      lead_cnt   <= lead_nxt;
      bit_cnt    <= bit_nxt;
      shift      <= shift_nxt;
      data_out   <= data_out_nxt;
      data_valid <= valid_nxt;
      frame_err  <= err_nxt;
      overrun    <= ovr_nxt;
    end
  end

  // Frame FSM: the sclk sample is applied first, then the end-of-frame check
  // sees the updated count and shift value.
  always_comb begin
    state_nxt    = state;
    lead_nxt     = lead_cnt;
    bit_nxt      = bit_cnt;
    shift_nxt    = shift;
    data_out_nxt = data_out;
    valid_nxt    = data_valid;
    err_nxt      = 1'b0;
    ovr_nxt      = 1'b0;

    if (data_valid && data_ready) valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (de_rise && armed) begin
          state_nxt = (LEAD_BITS == 0) ? SHIFT : LEAD;
          lead_nxt  = '0;
          bit_nxt   = '0;
          shift_nxt = '0;
        end
      end
      LEAD: begin
        if (sclk_fall) begin
          lead_nxt = lead_cnt + LEAD_W'(1);
          if (lead_nxt == LEAD_W'(LEAD_BITS)) state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_fall) begin
          shift_nxt = {shift[WIDTH-2:0], sdi_s};
          // Saturate at WIDTH+1 so an over-long frame stays distinguishable
          if (bit_cnt != CNT_W'(WIDTH + 1)) bit_nxt = bit_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE && de_fall) begin
      state_nxt = IDLE;
      if (state == SHIFT && bit_nxt == CNT_W'(WIDTH)) begin
        if (!data_valid || data_ready) begin
          data_out_nxt = shift_nxt;
          valid_nxt    = 1'b1;
        end else begin
          ovr_nxt = 1'b1;
        end
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

endmodule
